// File: rtl/conv3_pkg.sv
// Shared widths and the state encoding for the CONV3 layer sequencer.
package conv3_pkg;

    localparam int BW_PER_ACT   = 12;
    localparam int BW_PER_PARAM = 8;
    localparam int CONV3_BW     = 23;
    localparam int ADDR_W       = 12;
    localparam int MAX_MAP_W    = 16;
    localparam int MW_W         = 5;
    localparam int SCALE_W      = 5;
    localparam int N_CH         = 8;

    localparam int ACT_WORD_W = 4 * BW_PER_ACT;       // 2x2 pixels per activation word
    localparam int WVEC_W     = 9 * BW_PER_PARAM;     // 3x3 kernel
    localparam int W_WORD_W   = WVEC_W + BW_PER_PARAM; // kernel plus bias
    localparam int WIN_W      = 16 * BW_PER_ACT;      // 4x4 window
    localparam int CONV_OUT_W = 4 * CONV3_BW;         // 2x2 results per channel
    localparam int BLK_W      = MW_W;
    localparam int ACT_MAX    = (1 << (BW_PER_ACT - 1)) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_FETCH,
        S_FILL,
        S_CONV,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv3_requant.sv
// Requantizes one CONV3 result pixel: add scaled bias, arithmetic shift, ReLU, clip.
module conv3_requant
    import conv3_pkg::*;
(
    input  logic [CONV3_BW-1:0]     acc,
    input  logic [BW_PER_PARAM-1:0] bias,
    input  logic [SCALE_W-1:0]      scale,
    output logic [BW_PER_ACT-1:0]   pix
);

    // Wide enough for a bias shifted by the maximum scale without overflow.
    localparam int SUM_W = BW_PER_PARAM + (1 << SCALE_W) + 1;
    localparam logic signed [SUM_W-1:0] CLIP = SUM_W'(ACT_MAX);

    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] bias_sh;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;

    always_comb begin
        acc_ext = {{(SUM_W - CONV3_BW){acc[CONV3_BW-1]}}, acc};
        bias_sh = {{(SUM_W - BW_PER_PARAM){bias[BW_PER_PARAM-1]}}, bias} <<< scale;
        sum     = acc_ext + bias_sh;
        shifted = sum >>> scale;
        if (shifted[SUM_W-1]) begin
            pix = '0;
        end else if (shifted > CLIP) begin
            pix = BW_PER_ACT'(ACT_MAX);
        end else begin
            pix = shifted[BW_PER_ACT-1:0];
        end
    end

endmodule

// File: rtl/conv3_sched.sv
// Layer sequencer for the 8-channel CONV3 datapath: weight load, 2x2-block raster
// walk, window assembly, result capture and requantized output writes.
module conv3_sched
    import conv3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MW_W-1:0]       map_w,
    input  logic [ADDR_W-1:0]     act_base,
    input  logic [ADDR_W-1:0]     w_base,
    input  logic [ADDR_W-1:0]     out_base,
    input  logic [SCALE_W-1:0]    scale,
    output logic                  busy,
    output logic                  done,
    output logic                  act_rd_en,
    output logic [ADDR_W-1:0]     act_addr,
    input  logic [ACT_WORD_W-1:0] act_rdata,
    output logic                  w_rd_en,
    output logic [ADDR_W-1:0]     w_addr,
    input  logic [W_WORD_W-1:0]   w_rdata,
    output logic                  out_wr_en,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [ACT_WORD_W-1:0] out_wdata,
    output logic [WIN_W-1:0]      f0,
    output logic [WVEC_W-1:0]     w0,
    output logic [WVEC_W-1:0]     w1,
    output logic [WVEC_W-1:0]     w2,
    output logic [WVEC_W-1:0]     w3,
    output logic [WVEC_W-1:0]     w4,
    output logic [WVEC_W-1:0]     w5,
    output logic [WVEC_W-1:0]     w6,
    output logic [WVEC_W-1:0]     w7,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch0,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch1,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch2,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch3,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch4,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch5,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch6,
    input  logic [CONV_OUT_W-1:0] conv3_f_ch7
);

    state_t                  state;
    logic [3:0]              cnt;

    logic [MW_W-1:0]         mw_q;
    logic [ADDR_W-1:0]       act_base_q;
    logic [ADDR_W-1:0]       out_base_q;
    logic [SCALE_W-1:0]      scale_q;
    logic [ADDR_W-1:0]       npix;

    logic [BLK_W-1:0]        r_q;
    logic [BLK_W-1:0]        c_q;
    logic [ADDR_W-1:0]       act_ptr;
    logic [ADDR_W-1:0]       blk_idx;

    logic [ACT_WORD_W-1:0]   act_buf [3];
    logic [WVEC_W-1:0]       w_q     [N_CH];
    logic [BW_PER_PARAM-1:0] bias_q  [N_CH];
    logic [CONV_OUT_W-1:0]   capt    [N_CH];
    logic [CONV_OUT_W-1:0]   conv_in [N_CH];

    logic [ADDR_W-1:0]       mw_ext;
    logic                    last_blk;
    logic [BLK_W-1:0]        nxt_r;
    logic [BLK_W-1:0]        nxt_c;
    logic [ADDR_W-1:0]       nxt_ptr;
    logic [BW_PER_ACT-1:0]   rq_pix [4];

    assign conv_in[0] = conv3_f_ch0;
    assign conv_in[1] = conv3_f_ch1;
    assign conv_in[2] = conv3_f_ch2;
    assign conv_in[3] = conv3_f_ch3;
    assign conv_in[4] = conv3_f_ch4;
    assign conv_in[5] = conv3_f_ch5;
    assign conv_in[6] = conv3_f_ch6;
    assign conv_in[7] = conv3_f_ch7;

    assign w0 = w_q[0];
    assign w1 = w_q[1];
    assign w2 = w_q[2];
    assign w3 = w_q[3];
    assign w4 = w_q[4];
    assign w5 = w_q[5];
    assign w6 = w_q[6];
    assign w7 = w_q[7];

    assign mw_ext = {{(ADDR_W - MW_W){1'b0}}, mw_q};

    // Raster successor of the current block; the next row starts 2 words on.
    always_comb begin
        last_blk = (r_q == mw_q - 5'd2) && (c_q == mw_q - 5'd2);
        if (c_q == mw_q - 5'd2) begin
            nxt_c   = '0;
            nxt_r   = r_q + 5'd1;
            nxt_ptr = act_ptr + 12'd2;
        end else begin
            nxt_c   = c_q + 5'd1;
            nxt_r   = r_q;
            nxt_ptr = act_ptr + 12'd1;
        end
    end

    // During WRITE, cnt is the channel being written.
    for (genvar p = 0; p < 4; p++) begin : g_rq
        conv3_requant u_rq (
            .acc   (capt[cnt[2:0]][CONV_OUT_W-1-p*CONV3_BW -: CONV3_BW]),
            .bias  (bias_q[cnt[2:0]]),
            .scale (scale_q),
            .pix   (rq_pix[p])
        );
    end

    // NOTE: out_wdata is decoded from registered state only and forced to zero
    // whenever no write is in flight, so it cannot glitch into the SRAM.
    assign out_wdata = out_wr_en ? {rq_pix[0], rq_pix[1], rq_pix[2], rq_pix[3]} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            act_rd_en  <= 1'b0;
            act_addr   <= '0;
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            out_wr_en  <= 1'b0;
            out_addr   <= '0;
            f0         <= '0;
            mw_q       <= '0;
            act_base_q <= '0;
            out_base_q <= '0;
            scale_q    <= '0;
            npix       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            act_ptr    <= '0;
            blk_idx    <= '0;
            // NOTE: these small register arrays are flops, not SRAM macros, so
            // they take the async reset like every other piece of state.
            for (int i = 0; i < N_CH; i++) begin
                w_q[i]    <= '0;
                bias_q[i] <= '0;
                capt[i]   <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                act_buf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mw_q       <= map_w;
                        act_base_q <= act_base;
                        out_base_q <= out_base;
                        scale_q    <= scale;
                        npix       <= ({7'd0, map_w} - 12'd1) * ({7'd0, map_w} - 12'd1);
                        busy       <= 1'b1;
                        w_rd_en    <= 1'b1;
                        w_addr     <= w_base;
                        cnt        <= '0;
                        state      <= S_WLOAD;
                    end
                end
                S_WLOAD: begin
                    if (cnt != 4'd0) begin
                        w_q[3'(cnt - 4'd1)]    <= w_rdata[W_WORD_W-1 -: WVEC_W];
                        bias_q[3'(cnt - 4'd1)] <= w_rdata[BW_PER_PARAM-1:0];
                    end
                    if (cnt == 4'd7) begin
                        w_rd_en <= 1'b0;
                    end else if (cnt < 4'd7) begin
                        w_addr <= w_addr + 12'd1;
                    end
                    if (cnt == 4'd8) begin
                        cnt <= '0;
                        if (mw_q < 5'd2) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            r_q       <= '0;
                            c_q       <= '0;
                            blk_idx   <= '0;
                            act_ptr   <= act_base_q;
                            act_addr  <= act_base_q;
                            act_rd_en <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_FETCH: begin
                    if (cnt != 4'd0) begin
                        act_buf[2'(cnt - 4'd1)] <= act_rdata;
                    end
                    cnt <= cnt + 4'd1;
                    case (cnt)
                        4'd0:    act_addr <= act_ptr + 12'd1;
                        4'd1:    act_addr <= act_ptr + mw_ext;
                        4'd2:    act_addr <= act_ptr + mw_ext + 12'd1;
                        default: begin
                            act_rd_en <= 1'b0;
                            cnt       <= '0;
                            state     <= S_FILL;
                        end
                    endcase
                end
                S_FILL: begin
                    // Buffers hold TL, TR, BL; BR is arriving from the SRAM now.
                    f0 <= {act_buf[0][47:24], act_buf[1][47:24],
                           act_buf[0][23:0],  act_buf[1][23:0],
                           act_buf[2][47:24], act_rdata[47:24],
                           act_buf[2][23:0],  act_rdata[23:0]};
                    state <= S_CONV;
                end
                S_CONV: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    for (int i = 0; i < N_CH; i++) begin
                        capt[i] <= conv_in[i];
                    end
                    out_wr_en <= 1'b1;
                    out_addr  <= out_base_q + blk_idx;
                    cnt       <= '0;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (cnt == 4'd7) begin
                        out_wr_en <= 1'b0;
                        cnt       <= '0;
                        if (last_blk) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            r_q       <= nxt_r;
                            c_q       <= nxt_c;
                            act_ptr   <= nxt_ptr;
                            act_addr  <= nxt_ptr;
                            act_rd_en <= 1'b1;
                            blk_idx   <= blk_idx + 12'd1;
                            state     <= S_FETCH;
                        end
                    end else begin
                        out_addr <= out_addr + npix;
                        cnt      <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3_sched.sv
// Self-checking bench for conv3_sched: SRAM and CONV3 stand-ins plus a pixel-map
// convolution reference that predicts every output write.
module tb_conv3_sched;
    import conv3_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [MW_W-1:0]       map_w = '0;
    logic [ADDR_W-1:0]     act_base = '0;
    logic [ADDR_W-1:0]     w_base = '0;
    logic [ADDR_W-1:0]     out_base = '0;
    logic [SCALE_W-1:0]    scale = '0;
    logic                  busy, done;
    logic                  act_rd_en, w_rd_en, out_wr_en;
    logic [ADDR_W-1:0]     act_addr, w_addr, out_addr;
    logic [ACT_WORD_W-1:0] act_rdata = '0;
    logic [W_WORD_W-1:0]   w_rdata = '0;
    logic [ACT_WORD_W-1:0] out_wdata;
    logic [WIN_W-1:0]      f0;
    logic [WVEC_W-1:0]     w0, w1, w2, w3, w4, w5, w6, w7;
    logic [WVEC_W-1:0]     wv [8];
    logic [CONV_OUT_W-1:0] conv_q [8];

    logic [ACT_WORD_W-1:0] act_mem [4096];
    logic [W_WORD_W-1:0]   w_mem   [4096];

    int img [32][32];
    int wt  [8][9];
    int bs  [8];

    typedef struct {
        logic [ADDR_W-1:0]     addr;
        logic [ACT_WORD_W-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [ACT_WORD_W-1:0] first_wdata;

    always #5 clk = ~clk;

    conv3_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .map_w(map_w),
        .act_base(act_base), .w_base(w_base), .out_base(out_base), .scale(scale),
        .busy(busy), .done(done),
        .act_rd_en(act_rd_en), .act_addr(act_addr), .act_rdata(act_rdata),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_wdata(out_wdata),
        .f0(f0),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7),
        .conv3_f_ch0(conv_q[0]), .conv3_f_ch1(conv_q[1]),
        .conv3_f_ch2(conv_q[2]), .conv3_f_ch3(conv_q[3]),
        .conv3_f_ch4(conv_q[4]), .conv3_f_ch5(conv_q[5]),
        .conv3_f_ch6(conv_q[6]), .conv3_f_ch7(conv_q[7])
    );

    assign wv[0] = w0;
    assign wv[1] = w1;
    assign wv[2] = w2;
    assign wv[3] = w3;
    assign wv[4] = w4;
    assign wv[5] = w5;
    assign wv[6] = w6;
    assign wv[7] = w7;

    // SRAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (act_rd_en) act_rdata <= act_mem[act_addr];
        if (w_rd_en)   w_rdata   <= w_mem[w_addr];
    end

    // CONV3 stand-in: 3x3 valid correlation of the 4x4 window, one register stage.
    function automatic logic [CONV_OUT_W-1:0] conv3_model(input logic [WIN_W-1:0] win,
                                                          input logic [WVEC_W-1:0] k);
        logic [CONV_OUT_W-1:0] res;
        int acc;
        res = '0;
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                acc = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        acc += int'($signed(win[WIN_W-1-12*((oy+i)*4+ox+j) -: 12]))
                             * int'($signed(k[WVEC_W-1-8*(i*3+j) -: 8]));
                    end
                end
                res[CONV_OUT_W-1-23*(oy*2+ox) -: 23] = acc[22:0];
            end
        end
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 8; ch++) conv_q[ch] <= '0;
        end else begin
            for (int ch = 0; ch < 8; ch++) conv_q[ch] <= conv3_model(f0, wv[ch]);
        end
    end

    task automatic check(input string tag, input logic [WIN_W-1:0] got,
                         input logic [WIN_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int requant_model(input int acc, input int b, input int sh);
        longint v;
        v = (longint'(acc) + (longint'(b) <<< sh)) >>> sh;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        return int'(v);
    endfunction

    function automatic logic [WIN_W-1:0] window_model(input int r, input int c);
        logic [WIN_W-1:0] f;
        f = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                f[WIN_W-1-12*(i*4+j) -: 12] = 12'(img[2*r+i][2*c+j]);
        return f;
    endfunction

    // Loads the SRAM images and builds the expected write sequence from the pixel map.
    task automatic prepare(input int mw, input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] wb,
                           input logic [ADDR_W-1:0] ob, input int sc);
        logic [W_WORD_W-1:0]   wword;
        logic [ACT_WORD_W-1:0] aword;
        logic [ACT_WORD_W-1:0] d;
        int acc;
        int nb;
        for (int ch = 0; ch < 8; ch++) begin
            wword = '0;
            for (int k = 0; k < 9; k++) wword[W_WORD_W-1-8*k -: 8] = 8'(wt[ch][k]);
            wword[7:0] = 8'(bs[ch]);
            w_mem[12'(wb + ch)] = wword;
        end
        for (int br = 0; br < mw; br++) begin
            for (int bc = 0; bc < mw; bc++) begin
                for (int p = 0; p < 4; p++)
                    aword[ACT_WORD_W-1-12*p -: 12] = 12'(img[2*br+p/2][2*bc+p%2]);
                act_mem[12'(ab + br*mw + bc)] = aword;
            end
        end
        exp_q.delete();
        nb = mw - 1;
        for (int r = 0; r < nb; r++) begin
            for (int c = 0; c < nb; c++) begin
                for (int ch = 0; ch < 8; ch++) begin
                    for (int p = 0; p < 4; p++) begin
                        acc = 0;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                acc += img[2*r+p/2+i][2*c+p%2+j] * wt[ch][i*3+j];
                        d[ACT_WORD_W-1-12*p -: 12] = 12'(requant_model(acc, bs[ch], sc));
                    end
                    exp_q.push_back('{addr: 12'(ob + ch*nb*nb + r*nb + c), data: d});
                end
            end
        end
    endtask

    task automatic pulse_start(input int mw, input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] wb,
                               input logic [ADDR_W-1:0] ob, input int sc);
        @(negedge clk);
        map_w    = 5'(mw);
        act_base = ab;
        w_base   = wb;
        out_base = ob;
        scale    = 5'(sc);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        // Parameters are latched at start, so later port values must not matter.
        map_w    = 5'($urandom_range(0, 31));
        act_base = 12'($urandom);
        w_base   = 12'($urandom);
        out_base = 12'($urandom);
        scale    = 5'($urandom);
    endtask

    // Runs one layer; cycle 1 is the first cycle after the start edge.
    task automatic run_layer(input string name, input int mw, input logic [ADDR_W-1:0] ab,
                             input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ob,
                             input int sc, input bit poke);
        int lat, done_cyc, n_done, wr_idx, nb;
        bit busy_ok, overlap;
        lat = 9 + 15 * ((mw >= 2) ? (mw - 1) * (mw - 1) : 0) + 1;
        nb = (mw >= 2) ? mw - 1 : 1;
        done_cyc = -1;
        n_done = 0;
        wr_idx = 0;
        busy_ok = 1'b1;
        overlap = 1'b0;
        first_wdata = 'x;
        prepare(mw, ab, wb, ob, sc);
        pulse_start(mw, ab, wb, ob, sc);
        for (int cyc = 1; cyc <= lat + 4; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start = poke && (cyc == 5 || cyc == lat - 3);
            if (act_rd_en && w_rd_en) overlap = 1'b1;
            if (cyc <= lat && !busy) busy_ok = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_wr_en) begin
                if (wr_idx == 0) first_wdata = out_wdata;
                if (wr_idx < exp_q.size()) begin
                    check({name, "/wr_addr"}, WIN_W'(out_addr), WIN_W'(exp_q[wr_idx].addr));
                    check({name, "/wr_data"}, WIN_W'(out_wdata), WIN_W'(exp_q[wr_idx].data));
                    if (wr_idx % 8 == 0)
                        check({name, "/f0"}, f0, window_model((wr_idx / 8) / nb, (wr_idx / 8) % nb));
                end
                wr_idx++;
            end
        end
        start = 1'b0;
        check({name, "/done_cycle"}, WIN_W'(done_cyc), WIN_W'(lat));
        check({name, "/done_count"}, WIN_W'(n_done), WIN_W'(1));
        check({name, "/write_count"}, WIN_W'(wr_idx), WIN_W'(exp_q.size()));
        check({name, "/busy_held"}, WIN_W'(busy_ok), WIN_W'(1));
        check({name, "/busy_after"}, WIN_W'(busy), WIN_W'(0));
        check({name, "/rd_overlap"}, WIN_W'(overlap), WIN_W'(0));
    endtask

    task automatic fill_const(input int act, input int w, input int b);
        for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) img[y][x] = act;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 9; k++) wt[ch][k] = w;
            bs[ch] = b;
        end
    endtask

    task automatic fill_random();
        for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) img[y][x] = int'($urandom_range(0, 2047));
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 9; k++) wt[ch][k] = int'($urandom_range(0, 255)) - 128;
            bs[ch] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "/busy"}, WIN_W'(busy), WIN_W'(0));
        check({name, "/done"}, WIN_W'(done), WIN_W'(0));
        check({name, "/enables"}, WIN_W'({act_rd_en, w_rd_en, out_wr_en}), WIN_W'(0));
        check({name, "/addrs"}, WIN_W'({act_addr, w_addr, out_addr}), WIN_W'(0));
        check({name, "/wdata"}, WIN_W'(out_wdata), WIN_W'(0));
        check({name, "/f0"}, f0, WIN_W'(0));
        check({name, "/w0_w7"}, WIN_W'(w0 | w3 | w7), WIN_W'(0));
    endtask

    initial begin
        bit sram_touch;
        int mw;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        fill_const(1, 1, 0);
        run_layer("ones_mw2", 2, 12'h100, 12'h010, 12'h200, 0, 1'b0);
        check("ones_mw2/pixel9", WIN_W'(first_wdata), WIN_W'(48'h009009009009));

        for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) img[y][x] = (y * 37 + x * 5) % 2048;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 9; k++) wt[ch][k] = ((ch * 9 + k) % 7) - 3;
            bs[ch] = ch * 3 - 10;
        end
        run_layer("ramp_mw3", 3, 12'h040, 12'h3f0, 12'h800, 3, 1'b0);

        fill_const(100, -1, 0);
        run_layer("relu", 2, 12'h000, 12'h000, 12'h000, 0, 1'b0);
        check("relu/zero", WIN_W'(first_wdata), WIN_W'(0));

        fill_const(2047, 127, 0);
        run_layer("clip", 2, 12'h7fe, 12'h123, 12'hffc, 0, 1'b0);
        check("clip/max", WIN_W'(first_wdata), WIN_W'(48'h7ff7ff7ff7ff));

        fill_const(1, 1, 5);
        for (int ch = 0; ch < 8; ch++) wt[ch][0] = 2;
        run_layer("bias_shift", 2, 12'h010, 12'h020, 12'h030, 2, 1'b0);
        check("bias_shift/seven", WIN_W'(first_wdata), WIN_W'(48'h007007007007));

        // Abort mid-WRITE with reset, then a clean layer afterwards.
        fill_random();
        prepare(3, 12'h300, 12'h050, 12'h600, 8);
        pulse_start(3, 12'h300, 12'h050, 12'h600, 8);
        for (int k = 0; k < 400 && !out_wr_en; k++) @(negedge clk);
        check("abort/in_write", WIN_W'(out_wr_en), WIN_W'(1));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        sram_touch = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (act_rd_en || w_rd_en || out_wr_en) sram_touch = 1'b1;
        end
        check("abort/no_access", WIN_W'(sram_touch), WIN_W'(0));
        rst_n = 1'b1;
        fill_random();
        run_layer("after_abort", 3, 12'h300, 12'h050, 12'h600, 8, 1'b0);

        fill_random();
        run_layer("restart_ignored", 4, 12'h0a0, 12'h0b0, 12'h0c0, 7, 1'b1);

        run_layer("mw1_nowrite", 1, 12'h000, 12'h000, 12'h000, 0, 1'b0);
        run_layer("mw0_nowrite", 0, 12'h000, 12'h000, 12'h000, 0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            fill_random();
            mw = int'($urandom_range(2, 6));
            run_layer($sformatf("rand%0d_mw%0d", t, mw), mw, 12'($urandom), 12'($urandom),
                      12'($urandom), int'($urandom_range(4, 10)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv3_sched.md
Name: conv3_sched

Overview:
- Layer-level sequencer for the 8-output-channel CONV3 datapath (3x3 conv, 4x4 pixel window in, 2x2 outputs per channel, one internal register stage).
- Loads 8 weight/bias words once per layer, then walks the input map in 2x2-pixel blocks (valid conv, output block stride 1 block = 2 pixels).
- Per output block: fetches 4 activation words, assembles the 4x4 window, waits for CONV3, then requantizes and writes 8 output words.
- Sits between the activation/weight/output SRAMs and the CONV3 instance.

Parameters:
BW_PER_ACT, 12, bits per pixel
BW_PER_PARAM, 8, bits per weight/bias
CONV3_BW, 23, CONV3 result width per pixel
ADDR_W, 12, SRAM address width
MAX_MAP_W, 16, max input map width/height in 2x2 blocks
MW_W, 5, width of map_w

Ports:
clk  in  1  clock, all logic posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin layer; sampled only in IDLE
map_w  in  MW_W  input map side in blocks, legal 2..MAX_MAP_W
act_base / w_base / out_base  in  ADDR_W each  base addresses
scale  in  5  requant right-shift
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last write
act_rd_en / act_addr / act_rdata  out/out/in  1/ADDR_W/48  activation SRAM, 1-cycle read latency
w_rd_en / w_addr / w_rdata  out/out/in  1/ADDR_W/80  weight SRAM, word = {9 weights MSB-first, bias}, 1-cycle latency
out_wr_en / out_addr / out_wdata  out/out/out  1/ADDR_W/48  output SRAM write
f0  out  192  4x4 window to CONV3, row-major, pixel(0,0) at [191:180]
w0..w7  out  72 each  per-channel weights to CONV3
conv3_f_ch0..7  in  92 each  CONV3 results, top-left pixel at [91:69]

Behaviour:
- Reset: all outputs, registers, counters 0; state IDLE. Reset asserted mid-layer aborts immediately; no further SRAM access.
- States: IDLE -> WLOAD(9) -> FETCH(4) -> FILL(1) -> CONV(1) -> CAPT(1) -> WRITE(8) -> FETCH (next block) or DONE(1) -> IDLE.
- WLOAD: cycles 0..7 w_rd_en=1, w_addr=w_base+k; data for k latched into w_k/bias_k on cycle k+1.
- FETCH at block (r,c), r,c in 0..map_w-2: reads act_base + {r*map_w+c, r*map_w+c+1, (r+1)*map_w+c, (r+1)*map_w+c+1} (TL,TR,BL,BR) on consecutive cycles.
- Word layout {p00,p01,p10,p11}, MSB first. f0 rows: {TL.p00,TL.p01,TR.p00,TR.p01}, {TL.p10,TL.p11,TR.p10,TR.p11}, then the same from BL/BR. f0 registered; valid from FILL end.
- CONV: CONV3 internal register captures. CAPT: all 8 conv3_f_ch registered.
- WRITE cycle ch: out_wr_en=1, out_addr = out_base + ch*(map_w-1)^2 + r*(map_w-1) + c.
- out_wdata = 4 requantized pixels in CONV3 order.
- Requant per pixel: acc(23b signed) + sign-extended bias<<scale, arithmetic >>> scale, ReLU, clip to 0..2047. Result is 12b with MSB 0.
- Block order raster: c increments first, wraps to 0 with r+1. After (map_w-2,map_w-2) -> DONE.
- Block period 15 cycles. Total latency = 9 + 15*(map_w-1)^2 + 1.
- start while busy ignored. map_w, bases and scale are latched at start. map_w<2 -> DONE directly after WLOAD, no writes.
- f0/w* hold value outside updates; rd/wr enables never overlap.

Decomposition:
- conv3_pkg: width localparams (ACT word 48, W word 80, CONV3_BW 23), state enum, block-counter width.
- Sub-module conv3_requant: one pixel, combinational bias/shift/ReLU/clip. 4 instances on the channel selected by the WRITE counter.

Test Plan:
- map_w=2, all acts 1, all weights 1, bias 0, scale 0 -> exactly one block, 8 writes at out_base+0..7, each pixel 9 (0x009), done at cycle 25 after start.
- map_w=3, ramp activations -> 4 blocks, raster order, addresses per formula; f0 matches the golden 4x4 assembly.
- Weights -1, acts 100, bias 0 -> acc -900 -> ReLU output 0. Weights 127, acts 2047, scale 0 -> clip 2047.
- bias=5, scale=2, acc=10 -> (10+20)>>>2 = 7.
- rst_n pulsed low during WRITE -> all outputs 0 same cycle, IDLE. Next start runs full layer correctly.
- start re-asserted while busy -> ignored. No second done; busy stays high continuously.
